arb_onehot_mux: RTL
===================

# arb_onehot_mux

Parametrised successor to the combinational one-hot mux. It takes NUM_CH valid/ready requestor channels of DATA_W bits and builds a one-hot grant from a fixed-priority or round-robin arbiter. The granted channel is selected through an AND-OR tree into a single registered valid/ready output stage. It sits between several producers and one shared consumer, such as a shared bus or a downstream FIFO.

## Interface
Parameters:
- NUM_CH, default 4: number of requestor channels; legal range 2..32.
- DATA_W, default 8: data width per channel.
- RR_EN, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, where channel 0 is highest.
- ID_W, default $clog2(NUM_CH): derived; not overridden by users.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid_i  in  NUM_CH  per-channel request valid.
- req_data_i  in  NUM_CH*DATA_W  packed channel data; channel k occupies bits [k*DATA_W +: DATA_W].
- req_ready_o  out  NUM_CH  one-hot (or zero) accept strobe; combinational.
- out_valid_o  out  1  output register holds a word.
- out_ready_i  in  1  consumer accepts the word this cycle.
- out_data_o  out  DATA_W  registered selected data.
- out_id_o  out  ID_W  registered index of the channel that supplied out_data_o.

## Operation
Load enable:
- load_en = !out_valid_o || out_ready_i.

Arbitration (combinational):
- Fixed priority mode: grant is the lowest-index asserted bit of req_valid_i.
- Round-robin mode: search starts at ptr, proceeds upward and wraps modulo NUM_CH; the first asserted bit wins.
- grant is always one-hot, or all-zero when no channel is valid.

Request side:
- req_ready_o = grant when load_en is 1 and reset is 0; otherwise req_ready_o = 0.
- A transfer on channel k occurs when req_valid_i[k] and req_ready_o[k] are both 1.

Output register update:
- load_en=1 and a grant exists: out_valid_o←1, out_data_o←AND-OR(grant, req_data_i), out_id_o←index(grant).
- load_en=1 and no channel valid: out_valid_o←0; out_data_o and out_id_o hold.
- load_en=0 (stalled): all output registers hold.

Round-robin pointer:
- When a transfer occurs on channel k, ptr←(k+1) mod NUM_CH.
- Otherwise ptr holds.
- When RR_EN=0, ptr exists but is unused.

Requestor contract:
- Producers hold valid and data stable until accepted.
- The block does not latch unaccepted requests.

Reset:
- out_valid_o=0, out_data_o=0, out_id_o=0, ptr=0.
- req_ready_o=0 during every reset cycle.
- Reset asserted mid-stall discards the held word; nothing is replayed after reset.

## Timing
Latency and throughput:
- A request accepted in cycle n appears on out_valid_o/out_data_o in cycle n+1.
- Throughput is one word per cycle while out_ready_i stays high.

Stall and back-to-back behaviour:
- Stall passthrough: out_valid_o=1 and out_ready_i=1 in the same cycle both retires the current word and loads a new one. There is no bubble.
- When out_valid_o=1 and out_ready_i=0, req_ready_o is all-zero and ptr is frozen.

Boundary conditions:
- Pointer wrap: after a grant to channel NUM_CH-1, ptr wraps to 0.
- A valid that drops without being granted leaves no effect.
- With a single active channel, that channel is granted every cycle regardless of ptr.

## Structure
Package arb_mux_pkg holds:
- function onehot_to_idx (parametrised by width via a generic loop).
- function and_or_mux (one-hot select of packed data).

Sub-module rr_arbiter:
- Parameters NUM_CH, RR_EN.
- Inputs: req, ptr. Output: one-hot grant.
- Purely combinational; implemented with a double-width masked search.

Ownership:
- The top level owns ptr, the output register, and load_en.
- The top level and rr_arbiter are each instantiated once.

## Test plan
- Reset: hold reset 2 cycles with all req_valid_i=1. Required: req_ready_o=0, out_valid_o=0, out_data_o=0, out_id_o=0; after release, the first grant goes to channel 0.
- Round-robin fairness: NUM_CH=4, RR_EN=1, all channels valid with data 8'hA0..8'hA3, out_ready_i=1. Required: out_id_o sequence 0,1,2,3,0 and out_data_o A0,A1,A2,A3,A0 on consecutive cycles.
- Fixed priority: RR_EN=0, channels 0 and 2 valid. Required: channel 0 is granted every cycle and channel 2 never; after channel 0 drops, channel 2 is granted the next cycle.
- Backpressure: out_valid_o=1 with out_id_o=1, then out_ready_i=0 for 3 cycles. Required: out_data_o/out_id_o stable, req_ready_o=0, ptr stays 2; after ready rises, channel 2 is granted in the same cycle.
- Wrap and sparse request: ptr=3, only channel 2 valid. Required: channel 2 is granted and ptr becomes 3; drive a pointer-wrap case and verify ptr 3→0.
- Reset mid-stream: assert reset while out_valid_o=1 and out_ready_i=0. Required: out_valid_o=0 next cycle, no duplicate or replayed word, ptr=0.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// arb_mux_pkg: shared helpers for the one-hot arbiter mux (index encode, AND-OR select)
package arb_mux_pkg;
  localparam int MAX_CH = 32;
  localparam int MAX_ID_W = 5;
  function automatic logic [MAX_ID_W-1:0] onehot_to_idx(input logic [MAX_CH-1:0] oh);
    logic [MAX_ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CH; i++) idx |= oh[i] ? MAX_ID_W'(i) : '0;
    return idx;
  endfunction
  // One bit-column of the AND-OR tree: col[k] is bit b of channel k's data.
  function automatic logic and_or_mux(input logic [MAX_CH-1:0] oh, input logic [MAX_CH-1:0] col);
    return |(oh & col);
  endfunction
endpackage

// File: rtl/arb_onehot_mux_rr_arbiter.sv
// rr_arbiter: combinational one-hot grant, round-robin from ptr or fixed priority from 0
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter bit RR_EN = 1'b1,
  parameter int ID_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [ID_W-1:0]   ptr_i,
  output logic [NUM_CH-1:0] grant_o
);
  logic [ID_W-1:0] base;
  logic [2*NUM_CH-1:0] dbl, first;
  // Lower half keeps only requests at or above base; upper half catches the wrap.
  always_comb begin
    base = RR_EN ? ptr_i : '0;
    dbl = {req_i, req_i & ({NUM_CH{1'b1}} << base)};
    first = dbl & (~dbl + 1'b1);
    grant_o = first[NUM_CH-1:0] | first[2*NUM_CH-1:NUM_CH];
  end
endmodule

// File: rtl/arb_onehot_mux.sv
// arb_onehot_mux: arbitrates NUM_CH valid/ready channels into one registered output stage
module arb_onehot_mux
  import arb_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter bit RR_EN = 1'b1,
  parameter int ID_W = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] req_data_i,
  output logic [NUM_CH-1:0]        req_ready_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [ID_W-1:0]          out_id_o
);
  logic [NUM_CH-1:0] grant;
  logic [MAX_CH-1:0] col;
  logic [ID_W-1:0] gnt_id, ptr_q, ptr_d, out_id_q, out_id_d;
  logic [DATA_W-1:0] sel_data, out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, load_en, take;
  rr_arbiter #(.NUM_CH(NUM_CH), .RR_EN(RR_EN), .ID_W(ID_W)) u_arb (
    .req_i(req_valid_i),
    .ptr_i(ptr_q),
    .grant_o(grant)
  );
  always_comb begin
    col = '0;
    sel_data = '0;
    for (int b = 0; b < DATA_W; b++) begin
      col = '0;
      for (int k = 0; k < NUM_CH; k++) col[k] = req_data_i[k*DATA_W+b];
      sel_data[b] = and_or_mux(MAX_CH'(grant), col);
    end
    gnt_id = ID_W'(onehot_to_idx(MAX_CH'(grant)));
    load_en = !out_valid_q || out_ready_i;
    take = load_en && |grant;
    req_ready_o = (load_en && !reset) ? grant : '0;
    out_valid_d = load_en ? |grant : out_valid_q;
    out_data_d = take ? sel_data : out_data_q;
    out_id_d = take ? gnt_id : out_id_q;
    ptr_d = take ? ((gnt_id == ID_W'(NUM_CH-1)) ? '0 : gnt_id + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_id_q <= '0;
      ptr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_id_q <= out_id_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_valid_o = out_valid_q;
  assign out_data_o = out_data_q;
  assign out_id_o = out_id_q;
endmodule
